// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_ctrl
// Description : Stall/flush/redirect control for a 5-stage pipeline, with
//               a pending-redirect state and saturating perf counters.
// Revision    : 1.0
// ============================================================================
module pipeline_stall_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_stall,
    input  logic        ifetch_req,
    input  logic        icache_resp,
    input  logic        dmem_req,
    input  logic        dcache_resp,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    input  logic        stat_clear,
    output logic        load_pc,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        clear_if_id,
    output logic        clear_id_ex,
    output logic        clear_ex_mem,
    output logic        pcmux_sel,
    output logic [15:0] redirect_pc,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t      r_state_q, w_state_d;
    logic [15:0] r_held_target_q, w_held_target_d;
    logic [15:0] r_stall_count_q, w_stall_count_d;
    logic [15:0] r_flush_count_q, w_flush_count_d;
    logic        w_dstall;
    logic        w_istall;
    logic        w_flush;

    assign w_dstall = dmem_req & ~dcache_resp;
    assign w_istall = ifetch_req & ~icache_resp;

    always_comb begin
        load_pc         = 1'b0;
        load_if_id      = 1'b0;
        load_id_ex      = 1'b0;
        load_ex_mem     = 1'b0;
        load_mem_wb     = 1'b0;
        clear_if_id     = 1'b0;
        clear_id_ex     = 1'b0;
        clear_ex_mem    = 1'b0;
        pcmux_sel       = 1'b0;
        w_flush         = 1'b0;
        w_state_d       = r_state_q;
        w_held_target_d = r_held_target_q;

        if (!rst) begin
            case (r_state_q)
                ST_RUN: begin
                    if (w_dstall) begin
                        // whole pipe frozen; a resolved branch waits for the D-cache
                    end else if (br_taken) begin
                        w_flush      = 1'b1;
                        load_if_id   = 1'b1;
                        load_id_ex   = 1'b1;
                        load_ex_mem  = 1'b1;
                        load_mem_wb  = 1'b1;
                        clear_if_id  = 1'b1;
                        clear_id_ex  = 1'b1;
                        clear_ex_mem = 1'b1;
                        if (!w_istall) begin
                            load_pc   = 1'b1;
                            pcmux_sel = 1'b1;
                        end else begin
                            w_held_target_d = br_target;
                            w_state_d       = ST_PEND;
                        end
                    end else if (hazard_stall || w_istall) begin
                        load_id_ex  = 1'b1;
                        clear_id_ex = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                    end else begin
                        load_pc     = 1'b1;
                        load_if_id  = 1'b1;
                        load_id_ex  = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                    end
                end
                ST_PEND: begin
                    if (w_dstall) begin
                        // frozen, redirect target retained
                    end else if (w_istall) begin
                        load_id_ex  = 1'b1;
                        clear_id_ex = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                    end else begin
                        // fetch returned on the wrong path: bubble it and redirect
                        load_pc     = 1'b1;
                        pcmux_sel   = 1'b1;
                        load_if_id  = 1'b1;
                        clear_if_id = 1'b1;
                        load_id_ex  = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                        w_state_d   = ST_RUN;
                    end
                end
                default: w_state_d = ST_RUN;
            endcase
        end
    end

    assign redirect_pc = (r_state_q == ST_PEND) ? r_held_target_q : br_target;

    always_comb begin
        w_stall_count_d = r_stall_count_q;
        w_flush_count_d = r_flush_count_q;
        if (stat_clear) begin
            w_stall_count_d = 16'h0000;
            w_flush_count_d = 16'h0000;
        end else begin
            if (!load_pc && (r_stall_count_q != C_CNT_MAX)) begin
                w_stall_count_d = r_stall_count_q + 16'h0001;
            end
            if (w_flush && (r_flush_count_q != C_CNT_MAX)) begin
                w_flush_count_d = r_flush_count_q + 16'h0001;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q       <= ST_RUN;
            r_held_target_q <= 16'h0000;
            r_stall_count_q <= 16'h0000;
            r_flush_count_q <= 16'h0000;
        end else begin
            r_state_q       <= w_state_d;
            r_held_target_q <= w_held_target_d;
            r_stall_count_q <= w_stall_count_d;
            r_flush_count_q <= w_flush_count_d;
        end
    end

    assign stall_count = r_stall_count_q;
    assign flush_count = r_flush_count_q;

endmodule
`default_nettype wire

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have the following ports; one clock, and reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- hazard_stall  in  1  load-use stall request from ID-stage hazard detection
- ifetch_req  in  1  I-cache read outstanding
- icache_resp  in  1  I-cache read complete this cycle
- dmem_req  in  1  MEM-stage D-cache access active
- dcache_resp  in  1  D-cache access complete this cycle
- br_taken  in  1  control transfer resolved taken in MEM
- br_target  in  16 (lc3b_word)  target PC for br_taken
- stat_clear  in  1  clear both counters
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  pipeline register load enables
- clear_if_id, clear_id_ex, clear_ex_mem  out  1 each  load a NOP bubble when the matching load is 1
- pcmux_sel  out  1  1 selects redirect_pc as next PC
- redirect_pc  out  16 (lc3b_word)  redirect target
- stall_count, flush_count  out  16 each  performance counters

Function
REQ-002 SHALL define dstall = dmem_req & ~dcache_resp and istall = ifetch_req & ~icache_resp.
REQ-003 SHALL implement a two-state FSM: RUN and PEND (redirect pending behind an in-flight I-fetch).
REQ-004 RUN priority 1, dstall: all loads 0, all clears 0, pcmux_sel 0, br_taken ignored, state held.
REQ-005 RUN priority 2, br_taken & ~istall: all loads 1, clear_if_id/id_ex/ex_mem 1, pcmux_sel 1, redirect_pc = br_target, stay in RUN.
REQ-006 RUN priority 2, br_taken & istall: load_pc 0, all other loads 1, three clears 1, br_target latched into held_target, go to PEND.
REQ-007 RUN priority 3, hazard_stall or istall (no br_taken): load_pc 0, load_if_id 0, load_id_ex 1 with clear_id_ex 1, load_ex_mem/mem_wb 1.
REQ-008 RUN priority 4, otherwise: all loads 1, all clears 0, pcmux_sel 0.
REQ-009 PEND with dstall: all loads 0, state held; held_target unchanged.
REQ-010 PEND with istall & ~dstall: load_pc 0, load_if_id 0, load_id_ex 1 with clear_id_ex 1, downstream loads 1; hazard_stall and br_taken ignored.
REQ-011 PEND with ~istall & ~dstall: the wrong-path fetch is discarded: load_pc 1, pcmux_sel 1, redirect_pc = held_target, load_if_id 1 with clear_if_id 1, other loads 1, go to RUN.
REQ-012 redirect_pc SHALL equal held_target in PEND and br_target in RUN (combinational).
REQ-013 All outputs except counters and redirect_pc SHALL be combinational from state, inputs and held_target; no added latency.
REQ-014 stall_count SHALL increment by 1 in every cycle where load_pc = 0 and rst = 0, saturating at 0xFFFF.
REQ-015 flush_count SHALL increment by 1 per taken branch, on the REQ-005/REQ-006 cycle only (not in PEND), saturating at 0xFFFF.
REQ-016 stat_clear SHALL zero both counters on the next edge and take priority over increment.

Reset
REQ-017 rst SHALL on the next edge force state RUN, held_target 0x0000, and stall_count/flush_count 0x0000, regardless of state, including mid-PEND.
REQ-018 While rst is 1, all loads and clears SHALL be 0 and pcmux_sel 0; counters SHALL NOT increment.

Verification
REQ-019 Load-use: hazard_stall 1 for one cycle, no memory stalls -> load_pc=load_if_id=0, clear_id_ex=1 for that cycle, stall_count +1.
REQ-020 D-miss: dmem_req 1, dcache_resp 0 for 5 cycles with br_taken 1 -> all loads 0 for 5 cycles; flush occurs on the dcache_resp cycle; flush_count 1; stall_count 5.
REQ-021 Branch with I-miss: br_taken 1, br_target 0x1234, istall for 3 more cycles -> PEND entered; on icache_resp cycle pcmux_sel 1, redirect_pc 0x1234, clear_if_id 1; flush_count 1.
REQ-022 Reset mid-PEND: rst asserted in PEND -> next cycle state RUN, counters 0, held_target 0.
REQ-023 Saturation: force 0x10000+ stall cycles -> stall_count holds 0xFFFF; stat_clear with concurrent stall -> 0x0000.
